// File: rtl/lookup3_key_packer.sv
// lookup3_key_packer: packs the first 12 key bytes MSB-first into k0..k2, counts
// the key length and presents one packed key per valid/ready handshake.
`default_nettype none

module lookup3_key_packer #(
    parameter int         MAX_LEN  = 250,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_abort,
    output logic        in_ready,
    output logic        key_valid,
    input  logic        out_ready,
    output logic [7:0]  key_length,
    output logic [31:0] k0,
    output logic [31:0] k1,
    output logic [31:0] k2,
    output logic        key_err
);

    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_COLLECT = 2'd1;
    localparam logic [1:0]  S_EMIT    = 2'd2;
    localparam logic [7:0]  C_MAX_LEN = MAX_LEN[7:0];
    localparam logic [31:0] C_PAD     = {4{PAD_BYTE}};

    logic [1:0]  state;
    logic        accept;
    logic [7:0]  idx;
    logic [7:0]  count_next;
    logic [4:0]  lane_base;
    logic [31:0] k0_next;
    logic [31:0] k1_next;
    logic [31:0] k2_next;

    always_comb begin
        accept     = in_valid & in_ready & ~in_abort;
        idx        = (state == S_IDLE) ? 8'd0 : key_length;
        count_next = (state == S_IDLE)      ? 8'd1 :
                     (key_length == 8'hFF)  ? 8'hFF : key_length + 8'd1;
        // Lane 0 of a word is its most significant byte.
        lane_base  = {~idx[1:0], 3'b000};
        k0_next    = (state == S_IDLE) ? C_PAD : k0;
        k1_next    = (state == S_IDLE) ? C_PAD : k1;
        k2_next    = (state == S_IDLE) ? C_PAD : k2;
        if (idx < 8'd12) begin
            case (idx[3:2])
                2'd0:    k0_next[lane_base +: 8] = in_data;
                2'd1:    k1_next[lane_base +: 8] = in_data;
                default: k2_next[lane_base +: 8] = in_data;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            key_valid  <= 1'b0;
            key_err    <= 1'b0;
            key_length <= 8'd0;
            k0         <= C_PAD;
            k1         <= C_PAD;
            k2         <= C_PAD;
        end else begin
            case (state)
                S_IDLE, S_COLLECT: begin
                    in_ready <= 1'b1;
                    if (in_abort) begin
                        // Abort wins over any byte or in_last in the same cycle.
                        state      <= S_IDLE;
                        key_length <= 8'd0;
                        k0         <= C_PAD;
                        k1         <= C_PAD;
                        k2         <= C_PAD;
                    end else if (accept) begin
                        k0         <= k0_next;
                        k1         <= k1_next;
                        k2         <= k2_next;
                        key_length <= count_next;
                        if (in_last) begin
                            state     <= S_EMIT;
                            key_valid <= 1'b1;
                            key_err   <= (count_next > C_MAX_LEN);
                            in_ready  <= 1'b0;
                        end else begin
                            state <= S_COLLECT;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        key_valid <= 1'b0;
                        key_err   <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lookup3_key_packer.sv
// tb_lookup3_key_packer: directed checks of lookup3_key_packer packing, length/error, stall, abort and reset.
`default_nettype none

module tb_lookup3_key_packer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_abort = 1'b0;
    logic        in_ready;
    logic        key_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  key_length;
    logic [31:0] k0, k1, k2;
    logic        key_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nlog = 0;
    logic [7:0]  key_buf [0:299];
    logic [31:0] log_k0 [0:1023];
    logic [31:0] log_k2 [0:1023];
    int          log_cyc [0:1023];

    lookup3_key_packer #(.MAX_LEN(250), .PAD_BYTE(8'h00)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_abort(in_abort), .in_ready(in_ready),
        .key_valid(key_valid), .out_ready(out_ready), .key_length(key_length),
        .k0(k0), .k1(k1), .k2(k2), .key_err(key_err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (key_valid && nlog < 1024) begin
            log_k0[nlog]  = k0;
            log_k2[nlog]  = k2;
            log_cyc[nlog] = cyc;
            nlog          = nlog + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) key_buf[i] = s[i];
    endtask

    task automatic load_count(input int n);
        for (int i = 0; i < n; i++) key_buf[i] = 8'(i + 1);
    endtask

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        while (!in_ready && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge CLK);
    endtask

    task automatic send_key(input int n);
        for (int i = 0; i < n; i++) send_byte(key_buf[i], (i == n - 1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_key(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [7:0] elen, input logic eerr);
        chk({tag, "_valid"}, 32'(key_valid), 32'd1);
        chk({tag, "_k0"}, k0, e0);
        chk({tag, "_k1"}, k1, e1);
        chk({tag, "_k2"}, k2, e2);
        chk({tag, "_len"}, 32'(key_length), 32'(elen));
        chk({tag, "_err"}, 32'(key_err), 32'(eerr));
    endtask

    initial begin
        int n0;
        logic [31:0] held;

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_key_err", 32'(key_err), 32'd0);
        chk("rst_len", 32'(key_length), 32'd0);
        chk("rst_k0", k0, 32'd0);
        chk("rst_k2", k2, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // 12-byte key, single pulse
        load_str("abcdefghijkl");
        send_key(12);
        check_key("k12", 32'h61626364, 32'h65666768, 32'h696A6B6C, 8'd12, 1'b0);
        @(negedge CLK);
        chk("k12_pulse", 32'(key_valid), 32'd0);

        // 9-byte and 1-byte keys
        load_str("abcdefghi");
        send_key(9);
        check_key("k9", 32'h61626364, 32'h65666768, 32'h69000000, 8'd9, 1'b0);
        @(negedge CLK);
        load_str("a");
        send_key(1);
        check_key("k1", 32'h61000000, 32'h0, 32'h0, 8'd1, 1'b0);
        @(negedge CLK);

        // Long keys: count only beyond byte 12, error above MAX_LEN
        load_count(300);
        send_key(20);
        check_key("k20", 32'h01020304, 32'h05060708, 32'h090A0B0C, 8'd20, 1'b0);
        @(negedge CLK);
        send_key(250);
        check_key("k250", 32'h01020304, 32'h05060708, 32'h090A0B0C, 8'd250, 1'b0);
        @(negedge CLK);
        send_key(251);
        check_key("k251", 32'h01020304, 32'h05060708, 32'h090A0B0C, 8'd251, 1'b1);
        @(negedge CLK);
        send_key(300);
        check_key("k300", 32'h01020304, 32'h05060708, 32'h090A0B0C, 8'd255, 1'b1);
        @(negedge CLK);

        // Consumer stall with the next byte held by the source
        out_ready = 1'b0;
        load_str("wxyz");
        send_key(4);
        check_key("stall", 32'h7778797A, 32'h0, 32'h0, 8'd4, 1'b0);
        held = k0;
        in_valid = 1'b1;
        in_data  = 8'h41;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("stall_valid", 32'(key_valid), 32'd1);
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_k0", k0, held);
        end
        out_ready = 1'b1;
        @(negedge CLK);
        chk("release_valid", 32'(key_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
        @(negedge CLK);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_key("after_stall", 32'h41000000, 32'h0, 32'h0, 8'd1, 1'b0);
        @(negedge CLK);

        // Abort mid-key, then a clean short key
        load_str("ABCDE");
        for (int i = 0; i < 5; i++) send_byte(key_buf[i], 1'b0);
        in_valid = 1'b0;
        in_abort = 1'b1;
        @(negedge CLK);
        in_abort = 1'b0;
        chk("abort_len", 32'(key_length), 32'd0);
        load_str("xy");
        send_key(2);
        check_key("post_abort", 32'h78790000, 32'h0, 32'h0, 8'd2, 1'b0);
        @(negedge CLK);

        // Abort together with in_last drops the key
        load_str("pq");
        send_byte(key_buf[0], 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h71;
        in_last  = 1'b1;
        in_abort = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_last_valid", 32'(key_valid), 32'd0);
            @(negedge CLK);
        end
        chk("abort_last_len", 32'(key_length), 32'd0);

        // Asynchronous reset mid-collect
        load_str("abcdefghijkl");
        for (int i = 0; i < 5; i++) send_byte(key_buf[i], 1'b0);
        in_valid = 1'b0;
        #3 RST = 1'b1;
        #1;
        chk("arst_ready", 32'(in_ready), 32'd0);
        chk("arst_len", 32'(key_length), 32'd0);
        chk("arst_k0", k0, 32'd0);
        chk("arst_k1", k1, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        send_key(12);
        check_key("post_rst", 32'h61626364, 32'h65666768, 32'h696A6B6C, 8'd12, 1'b0);
        @(negedge CLK);

        // Back-to-back 12-byte keys, no idle between them
        load_str("abcdefghijklmnopqrstuvwx");
        n0 = nlog;
        for (int i = 0; i < 24; i++) send_byte(key_buf[i], (i == 11) || (i == 23));
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("b2b_count", 32'(nlog - n0), 32'd2);
        chk("b2b_first_k0", log_k0[n0], 32'h61626364);
        chk("b2b_second_k0", log_k0[n0 + 1], 32'h6D6E6F70);
        chk("b2b_second_k2", log_k2[n0 + 1], 32'h75767778);
        chk("b2b_spacing", 32'(log_cyc[n0 + 1] - log_cyc[n0]), 32'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
